// File: rtl/dcache_pkg.sv
// Shared types and geometry for the L1 data cache: FSM states, line/word
// widths and helpers deriving index/tag widths from the set count.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, RESP, WB, FILL} state_t;

  localparam int OFFSET_W = 5;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int WORDS    = LINE_W / WORD_W;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// DEPTH x WIDTH flop array: combinational read, synchronous write with a
// per-byte enable, and an optional synchronous clear of every entry.
module dcache_array #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 8,
  parameter bit RESET_ZERO = 1'b0,
  localparam int AW        = $clog2(DEPTH),
  localparam int BE_W      = (WIDTH + 7) / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [BE_W-1:0]  be,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] bit_mask;

  // The last byte lane may be partial when WIDTH is not a multiple of 8.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign bit_mask[gi] = be[gi / 8];
  end

  always_ff @(posedge clk) begin
    if (RESET_ZERO && rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we) begin
      mem_reg[addr] <= (mem_reg[addr] & ~bit_mask) | (wdata & bit_mask);
    end
  end

  assign rdata = mem_reg[addr];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache between the CPU
// word port (dmem_*) and a 256-bit line memory port (pmem_*).
module l1_dcache
  import dcache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [3:0]        dmem_byte_enable,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [WORD_W-1:0] dmem_wdata,
  output logic              dmem_resp,
  output logic [WORD_W-1:0] dmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int IDX_W    = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, SETS);
  localparam int TAG_BE_W = (TAG_W + 7) / 8;

  state_t              state_reg, state_next;
  logic [WORD_W-1:0]   rdata_reg, rdata_next;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    addr_tag;
  logic [2:0]          word_sel;
  logic                req, hit;

  logic [LINE_W-1:0]   line_rd, line_wdata;
  logic [LINE_W/8-1:0] line_be, write_mask;
  logic                line_we;
  logic [TAG_W-1:0]    tag_rd;
  logic                tag_we;
  logic [1:0]          vd_rd, vd_wdata;  // {valid, dirty}
  logic                vd_we;
  logic [WORD_W-1:0]   line_words [WORDS];
  logic                unused_addr_bits;

  assign idx              = dmem_address[OFFSET_W +: IDX_W];
  assign addr_tag         = dmem_address[ADDR_W-1 -: TAG_W];
  assign word_sel         = dmem_address[4:2];
  assign req              = dmem_read | dmem_write;
  assign hit              = vd_rd[1] && (tag_rd == addr_tag);
  assign unused_addr_bits = ^dmem_address[1:0];

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign line_words[gi]        = line_rd[gi*WORD_W +: WORD_W];
    assign write_mask[gi*4 +: 4] = (word_sel == 3'(gi)) ? dmem_byte_enable : 4'b0000;
  end

  dcache_array #(.DEPTH(SETS), .WIDTH(LINE_W), .RESET_ZERO(1'b0)) u_data (
    .clk(clk), .rst(rst), .addr(idx), .we(line_we), .be(line_be),
    .wdata(line_wdata), .rdata(line_rd)
  );

  dcache_array #(.DEPTH(SETS), .WIDTH(TAG_W), .RESET_ZERO(1'b0)) u_tag (
    .clk(clk), .rst(rst), .addr(idx), .we(tag_we), .be({TAG_BE_W{1'b1}}),
    .wdata(addr_tag), .rdata(tag_rd)
  );

  dcache_array #(.DEPTH(SETS), .WIDTH(2), .RESET_ZERO(1'b1)) u_vd (
    .clk(clk), .rst(rst), .addr(idx), .we(vd_we), .be(1'b1),
    .wdata(vd_wdata), .rdata(vd_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
    end
  end

  // A simultaneous read and write is serviced as a write.
  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    line_we    = 1'b0;
    line_be    = '0;
    line_wdata = {WORDS{dmem_wdata}};
    tag_we     = 1'b0;
    vd_we      = 1'b0;
    vd_wdata   = 2'b10;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (hit) begin
            state_next = RESP;
            if (dmem_write) begin
              line_we  = 1'b1;
              line_be  = write_mask;
              vd_we    = 1'b1;
              vd_wdata = 2'b11;
            end else begin
              rdata_next = line_words[word_sel];
            end
          end else if (vd_rd == 2'b11) begin
            state_next = WB;
          end else begin
            state_next = FILL;
          end
        end
      end
      RESP: state_next = IDLE;
      WB: begin
        if (pmem_resp) begin
          vd_we      = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (pmem_resp) begin
          line_we    = 1'b1;
          line_be    = '1;
          line_wdata = pmem_rdata;
          tag_we     = 1'b1;
          vd_we      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_resp    = (state_reg == RESP);
    dmem_rdata   = rdata_reg;
    pmem_read    = (state_reg == FILL);
    pmem_write   = (state_reg == WB);
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_reg == WB) begin
      pmem_address = {tag_rd, idx, {OFFSET_W{1'b0}}};
      pmem_wdata   = line_rd;
    end else if (state_reg == FILL) begin
      pmem_address = {dmem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    end
  end

  // The CPU must hold its request until it has seen dmem_resp.
  assert property (@(posedge clk) disable iff (rst) !(dmem_read && dmem_write));
  assert property (@(posedge clk) disable iff (rst)
    (state_reg inside {RESP, WB, FILL}) |->
      $stable({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable}));

endmodule

// File: tb/tb_l1_dcache.sv
// Randomised scoreboard bench for l1_dcache: a flat-memory reference model
// predicts dmem responses and pmem traffic, a monitor checks them in order.
module tb_l1_dcache;

  logic         clk = 1'b0;
  logic         rst;
  logic         dmem_read, dmem_write;
  logic [3:0]   dmem_byte_enable;
  logic [31:0]  dmem_address, dmem_wdata;
  logic         dmem_resp;
  logic [31:0]  dmem_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  l1_dcache #(.SETS(16), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_byte_enable(dmem_byte_enable), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit hold_pmem = 1'b0;

  typedef enum {E_DRESP, E_PRD, E_PWR} ek_t;
  typedef struct {
    ek_t          kind;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [31:0]  word;
    bit           chk_word;
  } exp_t;
  exp_t exp_q[$];

  // Architectural memory (what the CPU should see) and the backing store
  // behind the pmem port; lines not yet touched hold init_line().
  logic [255:0] flat_mem [logic [26:0]];
  logic [255:0] phys_mem [logic [26:0]];
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];

  function automatic logic [255:0] init_line(input logic [26:0] ln);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) begin
      if (ln == 27'd2) l[w*32 +: 32] = 32'h1111_1111 + 32'h0111_1111 * 32'(w);
      else l[w*32 +: 32] = (32'(ln) * 32'h9E37_79B9) ^ (32'(w) * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    return l;
  endfunction

  function automatic logic [255:0] get_flat(input logic [26:0] ln);
    return flat_mem.exists(ln) ? flat_mem[ln] : init_line(ln);
  endfunction

  function automatic logic [255:0] get_phys(input logic [26:0] ln);
    return phys_mem.exists(ln) ? phys_mem[ln] : init_line(ln);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input ek_t k, input logic [31:0] a, input logic [255:0] l,
                          input logic [31:0] w, input bit c);
    exp_t e;
    e.kind = k; e.addr = a; e.line = l; e.word = w; e.chk_word = c;
    exp_q.push_back(e);
  endtask

  task automatic pop_exp(input ek_t seen, output exp_t e, output bit ok);
    n_cmp++;
    ok = 1'b0;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got %s, expected nothing", seen.name());
    end else begin
      e = exp_q.pop_front();
      if (e.kind != seen) begin
        n_bad++;
        $display("FAIL event: got %s, expected %s", seen.name(), e.kind.name());
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  // Reset discards dirty lines, so their architectural contents revert.
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        logic [26:0] vln;
        vln = {m_tag[i], 4'(i)};
        flat_mem[vln] = get_phys(vln);
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_req(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mbe, input bit use_want, input logic [31:0] want);
    logic [26:0]  ln;
    logic [3:0]   idx;
    logic [22:0]  tag;
    int           w, lat;
    bit           hit, got;
    logic [255:0] line;
    ln  = addr[31:5];
    idx = addr[8:5];
    tag = addr[31:9];
    w   = int'(addr[4:2]);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx])
        push_exp(E_PWR, {m_tag[idx], idx, 5'b0}, get_flat({m_tag[idx], idx}), 32'h0, 1'b0);
      push_exp(E_PRD, {ln, 5'b0}, '0, 32'h0, 1'b0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    line = get_flat(ln);
    if (is_wr) begin
      for (int b = 0; b < 4; b++)
        if (mbe[b]) line[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
      flat_mem[ln] = line;
      m_dirty[idx] = 1'b1;
      push_exp(E_DRESP, addr, '0, 32'h0, 1'b0);
    end else begin
      push_exp(E_DRESP, addr, '0, use_want ? want : line[w*32 +: 32], 1'b1);
    end

    dmem_read        = !is_wr;
    dmem_write       = is_wr;
    dmem_address     = addr;
    dmem_wdata       = wdata;
    dmem_byte_enable = mbe;
    lat = 0;
    got = 1'b0;
    while (lat < 200 && !got) begin
      @(negedge clk);
      lat++;
      if (dmem_resp) got = 1'b1;
    end
    if (!got) check("resp_timeout", 0, 1);
    else if (hit) check("hit_latency", lat, 2);
    @(posedge clk);
    #1;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
  endtask

  // Line memory responder with a random 1..4 cycle latency.
  initial begin : responder
    bit pend;
    int cnt;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    pend       = 1'b0;
    cnt        = 0;
    forever begin
      @(posedge clk);
      #1;
      pmem_resp = 1'b0;
      if (rst || !(pmem_read || pmem_write)) begin
        pend = 1'b0;
      end else if (!pend) begin
        pend = 1'b1;
        cnt  = $urandom_range(0, 3);
      end else if (!hold_pmem) begin
        if (cnt > 0) begin
          cnt--;
        end else begin
          pmem_resp = 1'b1;
          pend      = 1'b0;
          if (pmem_write) phys_mem[pmem_address[31:5]] = pmem_wdata;
          else pmem_rdata = get_phys(pmem_address[31:5]);
        end
      end
    end
  end

  initial begin : monitor
    bit   prev_rd, prev_wr, prev_resp, ok;
    exp_t e;
    prev_rd = 1'b0; prev_wr = 1'b0; prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_rd = 1'b0; prev_wr = 1'b0; prev_resp = 1'b0;
        continue;
      end
      if (pmem_write && !prev_wr) begin
        pop_exp(E_PWR, e, ok);
        if (ok) begin
          check("wb_addr", pmem_address, e.addr);
          check("wb_data", pmem_wdata, e.line);
        end
      end
      if (pmem_read && !prev_rd) begin
        pop_exp(E_PRD, e, ok);
        if (ok) check("fill_addr", pmem_address, e.addr);
      end
      if (dmem_resp) begin
        check("resp_gap", prev_resp, 0);
        pop_exp(E_DRESP, e, ok);
        if (ok && e.chk_word) check("rdata", dmem_rdata, e.word);
        if (ok) $display("resp addr=0x%08h rdata=0x%08h", e.addr, dmem_rdata);
      end
      prev_rd   = pmem_read;
      prev_wr   = pmem_write;
      prev_resp = dmem_resp;
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit seen;
    rst = 1'b1;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_byte_enable = 4'h0;
    dmem_address = 32'h0; dmem_wdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_resp", dmem_resp, 0);
    check("rst_dmem_rdata", dmem_rdata, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'h1111_1111);
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'h1111_1111);
    do_req(1'b1, 32'h0000_0044, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h0);
    do_req(1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b1, 32'h12BB_22DD);
    do_req(1'b0, 32'h0000_0240, 32'h0, 4'h0, 1'b0, 32'h0);

    // Abandon a fill with reset; set 2 holds a clean line so no writeback.
    hold_pmem = 1'b1;
    push_exp(E_PRD, 32'h0000_0440, '0, 32'h0, 1'b0);
    dmem_read    = 1'b1;
    dmem_address = 32'h0000_0440;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = pmem_read;
    end
    check("fill_started", seen, 1);
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b1;
    dmem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_fill_pmem_read", pmem_read, 0);
    check("rst_fill_dmem_resp", dmem_resp, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    hold_pmem = 1'b0;

    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'h1111_1111);
    do_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'h1111_1111);
    do_req(1'b0, 32'h0000_0048, 32'h0, 4'h0, 1'b0, 32'h0);
    do_req(1'b1, 32'h0000_004C, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0);
    do_req(1'b0, 32'h0000_004C, 32'h0, 4'h0, 1'b0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int          gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0, 32'h0);
    end

    repeat (5) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
